// File: rtl/region_attr_table.sv
// rtl/region_attr_table.sv - runtime-programmable physical-memory attribute table
//
// Holds NrRules base/length/attr rules (reset from parameters, rewritable
// through a request/grant register port) and answers address lookups with a
// registered one-cycle result under valid/ready flow control.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cfg_req_i, cfg_we_i          register request, 1 = write / 0 = read
//   cfg_idx_i, cfg_field_i       rule index; field 0 base, 1 length, 2 attr, 3 reserved
//   cfg_wdata_i                  write data (attr uses [3:0] = {lock, cached, exec, nonidem})
//   cfg_gnt_o                    grant, same cycle as request
//   cfg_rvalid_o, cfg_rdata_o    response one cycle after grant, zero-extended read data
//   cfg_err_o                    error, qualified by cfg_rvalid_o
//   lk_valid_i, lk_ready_o       lookup request handshake
//   lk_addr_i                    lookup address
//   lk_valid_o, lk_ready_i       lookup result handshake
//   lk_hit_o, lk_idx_o           matched flag and lowest matching rule index
//   lk_attr_o                    {cached, exec, nonidem}, DefaultAttr on a miss
module region_attr_table #(
  parameter int unsigned                    NrRules     = 3,
  parameter int unsigned                    AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0]   RstBase     = '0,
  parameter logic [NrRules*AddrWidth-1:0]   RstLength   = '0,
  parameter logic [NrRules*4-1:0]           RstAttr     = '0,
  parameter logic [2:0]                     DefaultAttr = 3'b000,
  localparam int unsigned                   IdxWidth    = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [AddrWidth-1:0] lk_addr_i,
  output logic                 lk_valid_o,
  input  logic                 lk_ready_i,
  output logic                 lk_hit_o,
  output logic [IdxWidth-1:0]  lk_idx_o,
  output logic [2:0]           lk_attr_o
);

  logic [AddrWidth-1:0] base_q   [NrRules];
  logic [AddrWidth-1:0] length_q [NrRules];
  logic [3:0]           attr_q   [NrRules];

  // Selected rule for the register port; an out-of-range index selects nothing.
  logic [AddrWidth-1:0] sel_base;
  logic [AddrWidth-1:0] sel_length;
  logic [3:0]           sel_attr;
  logic                 idx_ok;
  logic                 field_ok;
  logic                 cfg_err_d;
  logic                 wr_en;
  logic [AddrWidth-1:0] rd_val;

  always_comb begin
    sel_base   = '0;
    sel_length = '0;
    sel_attr   = '0;
    for (int i = 0; i < NrRules; i++) begin
      if (cfg_idx_i == IdxWidth'(i)) begin
        sel_base   = base_q[i];
        sel_length = length_q[i];
        sel_attr   = attr_q[i];
      end
    end
  end

  assign idx_ok    = 32'(cfg_idx_i) < NrRules;
  assign field_ok  = cfg_field_i != 2'd3;
  // The lock bit blocks every write to its rule, attr included, so only reset clears it.
  assign cfg_err_d = !idx_ok || !field_ok || (cfg_we_i && sel_attr[3]);
  assign wr_en     = cfg_req_i && cfg_we_i && !cfg_err_d;
  assign cfg_gnt_o = cfg_req_i;

  always_comb begin
    rd_val = '0;
    case (cfg_field_i)
      2'd0:    rd_val = sel_base;
      2'd1:    rd_val = sel_length;
      2'd2:    rd_val = AddrWidth'(sel_attr);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i]   <= RstBase[i*AddrWidth +: AddrWidth];
        length_q[i] <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i]   <= RstAttr[i*4 +: 4];
      end
    end else if (wr_en) begin
      for (int i = 0; i < NrRules; i++) begin
        if (cfg_idx_i == IdxWidth'(i)) begin
          case (cfg_field_i)
            2'd0:    base_q[i]   <= cfg_wdata_i;
            2'd1:    length_q[i] <= cfg_wdata_i;
            2'd2:    attr_q[i]   <= cfg_wdata_i[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && cfg_err_d;
      cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !cfg_err_d) ? rd_val : '0;
    end
  end

  // Match logic: scanning from the top index down lets the lowest match win.
  // The unsigned modular difference makes a rule that wraps past the top of
  // the address space match across the wrap.
  logic                 hit_d;
  logic [IdxWidth-1:0]  idx_d;
  logic [2:0]           attr_d;
  logic [AddrWidth-1:0] offset;

  always_comb begin
    hit_d  = 1'b0;
    idx_d  = '0;
    attr_d = DefaultAttr;
    offset = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      offset = lk_addr_i - base_q[i];
      if ((length_q[i] != '0) && (offset < length_q[i])) begin
        hit_d  = 1'b1;
        idx_d  = IdxWidth'(i);
        attr_d = attr_q[i][2:0];
      end
    end
  end

  assign lk_ready_o = !lk_valid_o || lk_ready_i;

  // Output stage holds its contents during a stall; table writes do not
  // refresh a held result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lk_valid_o <= 1'b0;
      lk_hit_o   <= 1'b0;
      lk_idx_o   <= '0;
      lk_attr_o  <= DefaultAttr;
    end else if (lk_valid_i && lk_ready_o) begin
      lk_valid_o <= 1'b1;
      lk_hit_o   <= hit_d;
      lk_idx_o   <= idx_d;
      lk_attr_o  <= attr_d;
    end else if (lk_ready_i) begin
      lk_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_region_attr_table.sv
// tb/tb_region_attr_table.sv - scoreboard bench for region_attr_table
module tb_region_attr_table;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam logic [N*AW-1:0] RB = {64'h0, 64'h0, 64'h0000_0000_8000_0000};
  localparam logic [N*AW-1:0] RL = {64'h0, 64'h0, 64'h0000_0000_4000_0000};
  localparam logic [N*4-1:0]  RA = {4'h0, 4'h0, 4'b0110};
  localparam logic [2:0]      DA = 3'b001;

  logic          clk, rst_i;
  logic          cfg_req_i, cfg_we_i;
  logic [1:0]    cfg_idx_i, cfg_field_i;
  logic [AW-1:0] cfg_wdata_i;
  logic          cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
  logic [AW-1:0] cfg_rdata_o;
  logic          lk_valid_i, lk_ready_o, lk_valid_o, lk_ready_i, lk_hit_o;
  logic [AW-1:0] lk_addr_i;
  logic [1:0]    lk_idx_o;
  logic [2:0]    lk_attr_o;

  region_attr_table #(
    .NrRules(N), .AddrWidth(AW), .RstBase(RB), .RstLength(RL),
    .RstAttr(RA), .DefaultAttr(DA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o), .lk_addr_i(lk_addr_i),
    .lk_valid_o(lk_valid_o), .lk_ready_i(lk_ready_i), .lk_hit_o(lk_hit_o),
    .lk_idx_o(lk_idx_o), .lk_attr_o(lk_attr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic last_rdy;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the table as plain arrays, lookups as the rule definition.
  logic [AW-1:0] m_base [N];
  logic [AW-1:0] m_len  [N];
  logic [3:0]    m_attr [N];
  logic [5:0]    lk_q   [$];
  logic [64:0]   cfg_q  [$];
  int            cfg_t  [$];

  task automatic model_reset();
    logic [N*AW-1:0] rb, rl;
    logic [N*4-1:0]  ra;
    rb = RB; rl = RL; ra = RA;
    for (int i = 0; i < N; i++) begin
      m_base[i] = rb[i*AW +: AW];
      m_len[i]  = rl[i*AW +: AW];
      m_attr[i] = ra[i*4 +: 4];
    end
  endtask

  function automatic logic [5:0] model_lookup(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    for (int i = 0; i < N; i++) begin
      d = a - m_base[i];
      if (m_len[i] != 0 && d < m_len[i]) return {1'b1, 2'(i), m_attr[i][2:0]};
    end
    return {1'b0, 2'd0, DA};
  endfunction

  task automatic model_cfg(input bit we, input logic [1:0] idx, input logic [1:0] fld,
                           input logic [AW-1:0] wd);
    bit            err;
    logic [AW-1:0] rd;
    err = (idx >= N) || (fld == 2'd3) || (we && m_attr[idx][3]);
    rd  = '0;
    if (!err && !we) rd = (fld == 0) ? m_base[idx] : (fld == 1) ? m_len[idx] : {60'h0, m_attr[idx]};
    if (!err && we) begin
      if (fld == 0) m_base[idx] = wd;
      else if (fld == 1) m_len[idx] = wd;
      else m_attr[idx] = wd[3:0];
    end
    cfg_q.push_back({err, rd});
    cfg_t.push_back(cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a consumed output.
  logic       held_v = 1'b0;
  logic [5:0] held;
  always @(negedge clk) begin
    logic [5:0]  e;
    logic [64:0] ce;
    int          ct;
    if (rst_i) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("lk_hold_stable", {lk_valid_o, lk_hit_o, lk_idx_o, lk_attr_o}, {1'b1, held});
      held_v = lk_valid_o && !lk_ready_i;
      held   = {lk_hit_o, lk_idx_o, lk_attr_o};
      if (lk_valid_o && lk_ready_i) begin
        if (lk_q.size() == 0) check("lk_unexpected", 1, 0);
        else begin
          e = lk_q.pop_front();
          check("lk_result", {lk_hit_o, lk_idx_o, lk_attr_o}, e);
        end
      end
      if (cfg_rvalid_o) begin
        if (cfg_q.size() == 0) check("cfg_unexpected", 1, 0);
        else begin
          ce = cfg_q.pop_front();
          ct = cfg_t.pop_front();
          check("cfg_resp", {cfg_err_o, cfg_rdata_o}, ce);
          check("cfg_latency", cyc, ct + 1);
        end
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input bit lv, input logic [AW-1:0] la, input bit lr,
                      input bit cr, input bit cw, input logic [1:0] ci,
                      input logic [1:0] cf, input logic [AW-1:0] cd, output bit acc);
    lk_valid_i = lv; lk_addr_i = la; lk_ready_i = lr;
    cfg_req_i = cr; cfg_we_i = cw; cfg_idx_i = ci; cfg_field_i = cf; cfg_wdata_i = cd;
    @(negedge clk);
    last_rdy = lk_ready_o;
    if (cr) check("cfg_gnt", cfg_gnt_o, 1);
    acc = lv && lk_ready_o;
    if (acc) lk_q.push_back(model_lookup(la));
    if (cr) model_cfg(cw, ci, cf, cd);
    @(posedge clk);
    #1;
    lk_valid_i = 1'b0; cfg_req_i = 1'b0;
  endtask

  task automatic lookup(input logic [AW-1:0] a);
    bit acc;
    for (int k = 0; k < 20; k++) begin
      step(1, a, 1, 0, 0, 0, 0, 0, acc);
      if (acc) return;
    end
    check("lk_accept_timeout", 0, 1);
  endtask

  task automatic cfg(input bit we, input logic [1:0] idx, input logic [1:0] fld,
                     input logic [AW-1:0] wd);
    bit acc;
    step(0, 0, 1, 1, we, idx, fld, wd, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    #1;
    check("rst_lk_valid", lk_valid_o, 0);
    check("rst_cfg_rvalid", cfg_rvalid_o, 0);
    check("rst_outputs", {cfg_err_o, cfg_rdata_o, lk_hit_o, lk_idx_o, lk_attr_o},
          {1'b0, 64'h0, 1'b0, 2'd0, DA});
    lk_q.delete(); cfg_q.delete(); cfg_t.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    bit            acc;
    logic [1:0]    ci, cf;
    logic [AW-1:0] a, d;
    int            r;
    rst_i = 1'b1; cfg_req_i = 0; cfg_we_i = 0; cfg_idx_i = 0; cfg_field_i = 0;
    cfg_wdata_i = 0; lk_valid_i = 0; lk_addr_i = 0; lk_ready_i = 1;
    @(posedge clk);
    #1;
    reset_dut();

    // Reset defaults
    lookup(64'h8000_1000);
    lookup(64'h7FFF_FFFF);
    cfg(0, 0, 2, 0);

    // Priority and disabled rules
    cfg(1, 0, 0, 64'h1_0000);
    cfg(1, 0, 1, 64'h100);
    cfg(1, 1, 0, 64'h0);
    cfg(1, 1, 1, 64'h2_0000);
    cfg(1, 1, 2, 64'h3);
    lookup(64'h1_0000);
    cfg(1, 0, 1, 64'h0);
    lookup(64'h1_0000);

    // Wrap-around
    cfg(1, 1, 1, 64'h0);
    cfg(1, 2, 0, 64'hFFFF_FFFF_FFFF_F000);
    cfg(1, 2, 1, 64'h2000);
    cfg(1, 2, 2, 64'h4);
    lookup(64'h800);
    lookup(64'hFFFF_FFFF_FFFF_F800);
    lookup(64'h1000);

    // Lock
    cfg(1, 2, 2, 64'h9);
    cfg(1, 2, 0, 64'h1234);
    cfg(0, 2, 0, 0);
    cfg(1, 2, 2, 64'h0);
    cfg(0, 2, 2, 0);
    lookup(64'h800);

    // Backpressure: ready low for 3 cycles after the first result
    lookup(64'h800);
    for (int k = 0; k < 3; k++) begin
      step(1, 64'h5, 0, 0, 0, 0, 0, 0, acc);
      check("bp_ready_low", last_rdy, 0);
    end
    lookup(64'h5);
    lookup(64'hFFFF_FFFF_FFFF_FFFF);
    lookup(64'h0);
    idle(2);

    // Randomized traffic
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, N - 1);
      a  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                       : m_base[r] + 64'($urandom_range(0, 'h3000)) - 64'h800;
      ci = 2'($urandom_range(0, 3));
      cf = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       d = 64'h0;
        1:       d = 64'h1000;
        2:       d = 64'hFFFF_FFFF_FFFF_F000;
        3:       d = 64'h2000;
        default: d = {$urandom, $urandom};
      endcase
      if (cf == 2) d = {60'h0, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7))};
      step($urandom_range(0, 1), a, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1), ci, cf, d, acc);
    end
    for (int k = 0; k < 20 && (lk_q.size() != 0 || cfg_q.size() != 0); k++) idle(1);
    check("drain_lk_q", lk_q.size(), 0);
    check("drain_cfg_q", cfg_q.size(), 0);

    // Race, invalid access, reset mid-operation
    reset_dut();
    step(1, 64'h8000_1000, 1, 1, 1, 0, 0, 64'h9000_0000, acc);
    lookup(64'h8000_1000);
    cfg(1, 3, 0, 64'h1);
    cfg(0, 3, 1, 0);
    cfg(1, 1, 3, 64'h1);
    idle(2);
    lookup(64'h9000_0010);
    step(0, 0, 0, 1, 0, 0, 0, 0, acc);
    check("pre_rst_lk_valid", lk_valid_o, 1);
    #2;
    reset_dut();
    lookup(64'h8000_1000);
    idle(3);
    check("final_lk_q", lk_q.size(), 0);
    check("final_cfg_q", cfg_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/region_attr_table.md
# region_attr_table

Runtime-programmable physical-memory attribute table, successor to the static non-idempotent/execute/cached region rule lists fixed in the core configuration. It holds `NrRules` base/length rules, each with attribute bits, reset from parameters and reprogrammable through a register port. It answers pipelined address lookups with a one-cycle registered result under valid/ready flow control. It sits between the core configuration and the fetch/load-store paths, where it replaces the hard-coded range checks.

## Interface
Parameters:
- `NrRules`, 3: number of rules, 1..16.
- `AddrWidth`, 64: physical address width.
- `RstBase`, `{NrRules*AddrWidth}'0`: packed reset bases; rule i is at `[i*AddrWidth +: AddrWidth]`.
- `RstLength`, `'0`: packed reset lengths, same packing as `RstBase`.
- `RstAttr`, `'0`: packed 4-bit reset attributes per rule, `{lock, cached, exec, nonidem}`.
- `DefaultAttr`, `3'b000`: `{cached, exec, nonidem}` returned on a miss.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `cfg_req_i`, in, 1: register access request.
- `cfg_we_i`, in, 1: 1 = write, 0 = read.
- `cfg_idx_i`, in, `$clog2(NrRules)` (min 1): rule index.
- `cfg_field_i`, in, 2: field select; 0 = base, 1 = length, 2 = attr, 3 = reserved.
- `cfg_wdata_i`, in, `AddrWidth`: write data; attr uses `[3:0]`.
- `cfg_gnt_o`, out, 1: grant, equal to `cfg_req_i`.
- `cfg_rvalid_o`, out, 1: response valid, one cycle after grant.
- `cfg_rdata_o`, out, `AddrWidth`: read data, zero-extended.
- `cfg_err_o`, out, 1: error, qualified by `cfg_rvalid_o`.
- `lk_valid_i`, in, 1: lookup request valid.
- `lk_ready_o`, out, 1: lookup request ready.
- `lk_addr_i`, in, `AddrWidth`: lookup address.
- `lk_valid_o`, out, 1: result valid.
- `lk_ready_i`, in, 1: result ready.
- `lk_hit_o`, out, 1: address matched a rule.
- `lk_idx_o`, out, `$clog2(NrRules)`: matching rule index.
- `lk_attr_o`, out, 3: `{cached, exec, nonidem}`.

## Operation
- Rule i matches when `length_i != 0` and `(addr - base_i) < length_i`. The subtraction is unsigned, modulo `2^AddrWidth`, so a rule that wraps past the top of the address space matches across the wrap. A length of 0 disables the rule.
- Priority: the lowest matching index wins. On a hit, `lk_attr_o` is the attr bits of that rule. On a miss, `lk_hit_o = 0`, `lk_idx_o = 0` and `lk_attr_o = DefaultAttr`.
- Writes:
  - A write updates the selected field at the clock edge.
  - If the rule's lock bit is set, the write is ignored and `cfg_err_o = 1`. This includes writes to the attr field, so a lock can be cleared only by reset.
  - An index `>= NrRules` or field 3 gives `cfg_err_o = 1` with no update.
  - A write to attr may set the lock bit; the write itself succeeds.
- Reads: return the base, the length or `{lock, cached, exec, nonidem}`. An invalid index or field returns `rdata = 0` with `err = 1`. Reads of locked rules succeed.
- Table state: base, length and attr registers per rule, plus one output register stage (valid, hit, idx, attr).

## Timing
- Reset values:
  - Table registers load `RstBase`, `RstLength` and `RstAttr`.
  - `lk_valid_o = 0`, `cfg_rvalid_o = 0`, `cfg_err_o = 0`.
  - `cfg_rdata_o = 0`, `lk_hit_o = 0`, `lk_idx_o = 0`, `lk_attr_o = DefaultAttr`.
- Lookup handshake:
  - Latency is 1 cycle: a request accepted at edge N presents its result from N until that result is consumed.
  - `lk_ready_o = !lk_valid_o || lk_ready_i`, which gives full throughput of one lookup per cycle.
  - The output register loads when `lk_valid_i && lk_ready_o`.
  - If there is no new request and `lk_ready_i = 1`, `lk_valid_o` clears.
  - While `lk_valid_o && !lk_ready_i`, all `lk_*_o` outputs hold stable.
- Config response: `cfg_rvalid_o` pulses exactly one cycle after each `cfg_req_i`. Back-to-back requests give back-to-back responses.
- Write/lookup race: a lookup accepted in the same cycle as a table write uses the old table contents. Lookups accepted on following cycles use the new contents.
- Held results are not recomputed after a table write.
- Reset asserted mid-operation clears the output stage and any pending config response asynchronously, and restores the table.

## Test plan
- **Reset defaults.** Reset with `NrRules = 3`; rule 0 = base `0x8000_0000`, length `0x4000_0000`, attr `0b0110`. Look up `0x8000_1000` → `hit = 1`, `idx = 0`, `attr = 3'b110`. Look up `0x7FFF_FFFF` → `hit = 0`, `attr = DefaultAttr`.
- **Priority and disabled rules.** Rules 0 and 1 both cover `0x1_0000`; look up `0x1_0000` → `idx = 0`. Write rule 0 length = 0, then repeat the lookup → `idx = 1`.
- **Wrap-around.** Program base `0xFFFF_FFFF_FFFF_F000`, length `0x2000`. Addresses `0x800` and `0xFFFF_FFFF_FFFF_F800` both hit. Address `0x1000` misses.
- **Lock.** Write attr `0b1001` to rule 2, then write the base of rule 2 → `err = 1` and the base is unchanged. Write attr `0` → `err = 1` and the lock is still set. Read attr → `0x9`, `err = 0`.
- **Backpressure.** Stream 4 lookups with `lk_ready_i` low for 3 cycles after the first. The first result holds stable, `lk_ready_o = 0` during the stall, and all 4 results then emerge in order with no loss.
- **Race and invalid access.** In the same cycle, write the rule 0 base and issue a lookup → the old-table result, with the new table visible on the next lookup. Write `idx = 3` → `err = 1` with `cfg_rvalid_o` one cycle later. Assert reset while `lk_valid_o = 1` → `lk_valid_o` drops immediately.
